// File: rtl/dictionary_lookup_arbiter.sv
// Shares one dictionary lookup datapath between NUM_REQ id streams using packet-granular
// round-robin arbitration, and routes each result beat back to the requester that issued it.
module dictionary_lookup_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int NUM_ELEMENTS = 16,
   parameter int ID_BITS      = 16,
   parameter int DATA_BITS    = 32,
   parameter int ROUTE_DEPTH  = 8
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic [NUM_REQ*NUM_ELEMENTS*ID_BITS-1:0] req_ids_data,
   input  logic [NUM_REQ*NUM_ELEMENTS-1:0]         req_ids_keep,
   input  logic [NUM_REQ-1:0]                      req_ids_last,
   input  logic [NUM_REQ-1:0]                      req_ids_valid,
   output logic [NUM_REQ-1:0]                      req_ids_ready,
   output logic [NUM_ELEMENTS*ID_BITS-1:0]         dict_ids_data,
   output logic [NUM_ELEMENTS-1:0]                 dict_ids_keep,
   output logic                                    dict_ids_last,
   output logic                                    dict_ids_valid,
   input  logic                                    dict_ids_ready,
   input  logic [NUM_ELEMENTS*DATA_BITS-1:0]       dict_res_data,
   input  logic [NUM_ELEMENTS-1:0]                 dict_res_keep,
   input  logic                                    dict_res_last,
   input  logic                                    dict_res_valid,
   output logic                                    dict_res_ready,
   output logic [NUM_ELEMENTS*DATA_BITS-1:0]       req_res_data,
   output logic [NUM_ELEMENTS-1:0]                 req_res_keep,
   output logic                                    req_res_last,
   output logic [NUM_REQ-1:0]                      req_res_valid,
   input  logic [NUM_REQ-1:0]                      req_res_ready,
   output logic [$clog2(NUM_REQ)-1:0]              grant,
   output logic                                    busy,
   output logic                                    state_dbg
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int PTR_W = $clog2(ROUTE_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int IDW   = NUM_ELEMENTS * ID_BITS;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ROUTE_DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
   localparam logic [IDX_W:0]   NREQ_EXT = (IDX_W + 1)'(NUM_REQ);

   typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   lock_idx_q, lock_idx_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]   last_grant_q;
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]   count_q;
   logic [IDX_W-1:0]   route_mem [ROUTE_DEPTH];

   logic [NUM_REQ-1:0] rot_valid;
   logic [IDX_W:0]     scan_sum;
   logic [IDX_W-1:0]   scan_idx;
   logic               scan_hit;
   logic [IDX_W-1:0]   winner;
   logic               offered;
   logic [IDX_W-1:0]   head;
   logic               not_full, not_empty;
   logic               id_fire, res_fire;

   // Round-robin scan: rotate valids so bit k is requester rr_ptr+k; the lowest set k wins.
   always_comb begin
      rot_valid = NUM_REQ'({req_ids_valid, req_ids_valid} >> rr_ptr_q);
      scan_hit  = 1'b0;
      scan_idx  = rr_ptr_q;
      scan_sum  = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (rot_valid[k]) begin
            scan_hit = 1'b1;
            scan_sum = {1'b0, rr_ptr_q} + (IDX_W + 1)'(k);
            scan_idx = (scan_sum >= NREQ_EXT) ? IDX_W'(scan_sum - NREQ_EXT) : IDX_W'(scan_sum);
         end
      end
   end

   always_comb begin
      winner  = scan_idx;
      offered = scan_hit;
      if (state_q == LOCKED) begin
         winner  = lock_idx_q;
         offered = req_ids_valid[lock_idx_q];
      end
   end

   assign dict_ids_data = req_ids_data[int'(winner)*IDW +: IDW];
   assign dict_ids_keep = req_ids_keep[int'(winner)*NUM_ELEMENTS +: NUM_ELEMENTS];
   assign dict_ids_last = req_ids_last[winner];
   assign req_res_data  = dict_res_data;
   assign req_res_keep  = dict_res_keep;
   assign req_res_last  = dict_res_last;
   assign head          = route_mem[rd_ptr_q];
   assign not_full      = (count_q != FULL_CNT);
   assign not_empty     = (count_q != '0);
   assign id_fire       = dict_ids_valid && dict_ids_ready;
   assign res_fire      = dict_res_valid && dict_res_ready;
   assign state_dbg     = logic'(state_q);

   // Handshakes: a beat transfers on a cycle where valid and ready are both high; valid never
   // waits on ready. Full/empty come from the registered count, so a same-cycle pop never
   // unblocks a push, and every ready/valid output is held low while rst is high.
   always_comb begin
      dict_ids_valid = !rst && offered && not_full;
      req_ids_ready  = '0;
      if (!rst && offered && not_full && dict_ids_ready) req_ids_ready[winner] = 1'b1;
      req_res_valid  = '0;
      if (!rst && not_empty && dict_res_valid) req_res_valid[head] = 1'b1;
      dict_res_ready = !rst && not_empty && req_res_ready[head];
      grant          = offered ? winner : last_grant_q;
      busy           = (state_q == LOCKED) || not_empty;
   end

   always_comb begin
      state_d    = state_q;
      lock_idx_d = lock_idx_q;
      rr_ptr_d   = rr_ptr_q;
      if (id_fire) begin
         if (dict_ids_last) begin
            state_d  = IDLE;
            rr_ptr_d = (winner == LAST_IDX) ? '0 : winner + IDX_W'(1);
         end else begin
            state_d    = LOCKED;
            lock_idx_d = winner;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         lock_idx_q   <= '0;
         rr_ptr_q     <= '0;
         last_grant_q <= '0;
      end else begin
         state_q    <= state_d;
         lock_idx_q <= lock_idx_d;
         rr_ptr_q   <= rr_ptr_d;
         if (id_fire) last_grant_q <= winner;
      end
   end

   // Route FIFO: one entry per beat in flight at the dictionary, oldest at rd_ptr.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (id_fire)  wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (res_fire) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({id_fire, res_fire})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (id_fire) route_mem[wr_ptr_q] <= winner;
   end

   // A result with nothing in flight has no owner and is left unaccepted.
   orphan_result_a: assert property (@(posedge clk) disable iff (rst)
      !(dict_res_valid && !not_empty));

endmodule

// File: tb/tb_dictionary_lookup_arbiter.sv
// Scoreboarded bench for dictionary_lookup_arbiter: requester drivers, a behavioural dictionary,
// and monitors on the id and result paths that pop hand-ordered expectations.
module tb_dictionary_lookup_arbiter;

   logic           clk, rst;
   logic [1023:0]  req_ids_data;
   logic [63:0]    req_ids_keep;
   logic [3:0]     req_ids_last, req_ids_valid, req_ids_ready;
   logic [255:0]   dict_ids_data;
   logic [15:0]    dict_ids_keep;
   logic           dict_ids_last, dict_ids_valid, dict_ids_ready;
   logic [511:0]   dict_res_data;
   logic [15:0]    dict_res_keep;
   logic           dict_res_last, dict_res_valid, dict_res_ready;
   logic [511:0]   req_res_data;
   logic [15:0]    req_res_keep;
   logic           req_res_last;
   logic [3:0]     req_res_valid, req_res_ready;
   logic [1:0]     grant;
   logic           busy, state_dbg;

   typedef struct {logic [511:0] data; logic [15:0] keep; logic last;} res_t;

   logic [7:0] pend_q [4][$];
   logic [7:0] exp_id_q[$];
   logic [7:0] exp_res_q[$];
   res_t       dq[$];
   logic       res_en;
   int         n_tests, n_fail;

   dictionary_lookup_arbiter dut (
      .clk(clk), .rst(rst),
      .req_ids_data(req_ids_data), .req_ids_keep(req_ids_keep), .req_ids_last(req_ids_last),
      .req_ids_valid(req_ids_valid), .req_ids_ready(req_ids_ready),
      .dict_ids_data(dict_ids_data), .dict_ids_keep(dict_ids_keep), .dict_ids_last(dict_ids_last),
      .dict_ids_valid(dict_ids_valid), .dict_ids_ready(dict_ids_ready),
      .dict_res_data(dict_res_data), .dict_res_keep(dict_res_keep), .dict_res_last(dict_res_last),
      .dict_res_valid(dict_res_valid), .dict_res_ready(dict_res_ready),
      .req_res_data(req_res_data), .req_res_keep(req_res_keep), .req_res_last(req_res_last),
      .req_res_valid(req_res_valid), .req_res_ready(req_res_ready),
      .grant(grant), .busy(busy), .state_dbg(state_dbg)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] ent(input int r, input int b, input bit l);
      return {3'(r), 4'(b), l};
   endfunction

   function automatic logic [255:0] make_ids(input int r, input int b);
      logic [255:0] v;
      for (int e = 0; e < 16; e++) v[e*16 +: 16] = {4'(r), 4'(b), 8'(e)};
      return v;
   endfunction

   function automatic logic [511:0] dict_fn(input logic [255:0] ids);
      logic [511:0] v;
      for (int e = 0; e < 16; e++) v[e*32 +: 32] = {ids[e*16 +: 16] ^ 16'hD1C7, ids[e*16 +: 16]};
      return v;
   endfunction

   function automatic logic [15:0] keep_of(input int r, input bit l);
      logic [15:0] full;
      full = 16'hFFFF;
      return l ? (full >> (r + 1)) : full;
   endfunction

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // driver tasks
   task automatic push_pend(input int r, input int b, input bit l);
      pend_q[r].push_back(ent(r, b, l));
   endtask

   task automatic push_exp(input int r, input int b, input bit l);
      exp_id_q.push_back(ent(r, b, l));
      exp_res_q.push_back(ent(r, b, l));
   endtask

   function automatic bit pend_empty();
      return pend_q[0].size() == 0 && pend_q[1].size() == 0 &&
             pend_q[2].size() == 0 && pend_q[3].size() == 0;
   endfunction

   task automatic wait_ids_idle(input string name);
      int cyc = 0;
      bit done = 1'b0;
      while (!done && cyc < 300) begin
         @(posedge clk); #1;
         cyc++;
         done = pend_empty() && exp_id_q.size() == 0;
      end
      check({name, "_ids_idle"}, done, 1);
   endtask

   task automatic wait_drain(input string name);
      int cyc = 0;
      bit done = 1'b0;
      while (!done && cyc < 300) begin
         @(posedge clk); #1;
         cyc++;
         done = pend_empty() && dq.size() == 0 && exp_id_q.size() == 0 && exp_res_q.size() == 0;
      end
      check({name, "_drain"}, done, 1);
   endtask

   task automatic do_reset(input bit inject);
      @(posedge clk); #1;
      rst = 1'b1;
      req_res_ready = 4'hF;
      if (inject) pend_q[1].push_back(ent(1, 9, 1'b1));
      @(negedge clk); #4;
      check("rst_dict_ids_valid", dict_ids_valid, 0);
      check("rst_req_ids_ready", req_ids_ready, 0);
      check("rst_req_res_valid", req_res_valid, 0);
      check("rst_dict_res_ready", dict_res_ready, 0);
      @(posedge clk); #1;
      foreach (pend_q[i]) pend_q[i].delete();
      dq.delete();
      exp_id_q.delete();
      exp_res_q.delete();
      rst = 1'b0;
      @(negedge clk); #4;
      check("post_rst_busy", busy, 0);
      check("post_rst_grant", grant, 0);
      check("post_rst_state", state_dbg, 0);
      check("post_rst_dict_ids_valid", dict_ids_valid, 0);
      check("post_rst_req_ids_ready", req_ids_ready, 0);
      check("post_rst_req_res_valid", req_res_valid, 0);
      check("post_rst_dict_res_ready", dict_res_ready, 0);
   endtask

   // requester drivers: present queue heads, pop on handshake just before the active edge
   initial begin
      req_ids_data  = '0;
      req_ids_keep  = '0;
      req_ids_last  = '0;
      req_ids_valid = '0;
      forever begin
         @(negedge clk);
         for (int r = 0; r < 4; r++) begin
            if (pend_q[r].size() > 0) begin
               req_ids_valid[r]             = 1'b1;
               req_ids_data[r*256 +: 256]   = make_ids(int'(pend_q[r][0][7:5]), int'(pend_q[r][0][4:1]));
               req_ids_keep[r*16 +: 16]     = keep_of(int'(pend_q[r][0][7:5]), pend_q[r][0][0]);
               req_ids_last[r]              = pend_q[r][0][0];
            end else begin
               req_ids_valid[r] = 1'b0;
               req_ids_last[r]  = 1'b0;
            end
         end
         #4;
         for (int r = 0; r < 4; r++)
            if (req_ids_valid[r] && req_ids_ready[r]) void'(pend_q[r].pop_front());
      end
   end

   // behavioural dictionary: one result per accepted id beat, in order
   initial begin
      dict_ids_ready = 1'b0;
      dict_res_valid = 1'b0;
      dict_res_data  = '0;
      dict_res_keep  = '0;
      dict_res_last  = 1'b0;
      forever begin
         @(negedge clk);
         dict_ids_ready = 1'b1;
         if (res_en && dq.size() > 0) begin
            dict_res_valid = 1'b1;
            dict_res_data  = dq[0].data;
            dict_res_keep  = dq[0].keep;
            dict_res_last  = dq[0].last;
         end else begin
            dict_res_valid = 1'b0;
         end
         #4;
         if (dict_res_valid && dict_res_ready) void'(dq.pop_front());
         if (dict_ids_valid && dict_ids_ready) begin
            res_t t;
            t.data = dict_fn(dict_ids_data);
            t.keep = dict_ids_keep;
            t.last = dict_ids_last;
            dq.push_back(t);
         end
      end
   end

   // scoreboard: id path monitor
   initial begin : ids_mon
      logic [7:0] e;
      forever begin
         @(negedge clk); #4;
         if (dict_ids_valid && dict_ids_ready) begin
            if (exp_id_q.size() == 0) check("ids_unexpected_beat", 1, 0);
            else begin
               e = exp_id_q.pop_front();
               check("ids_grant", grant, e[7:5]);
               check("ids_data", dict_ids_data, make_ids(int'(e[7:5]), int'(e[4:1])));
               check("ids_keep", dict_ids_keep, keep_of(int'(e[7:5]), e[0]));
               check("ids_last", dict_ids_last, e[0]);
            end
         end
      end
   end

   // scoreboard: result path monitor
   initial begin : res_mon
      logic [7:0] e;
      int hits;
      forever begin
         @(negedge clk); #4;
         hits = 0;
         if (req_res_valid != 4'h0) check("res_valid_onehot", $onehot(req_res_valid), 1);
         for (int r = 0; r < 4; r++) begin
            if (req_res_valid[r] && req_res_ready[r]) begin
               hits++;
               if (exp_res_q.size() == 0) check("res_unexpected_beat", 1, 0);
               else begin
                  e = exp_res_q.pop_front();
                  check("res_owner", r, e[7:5]);
                  check("res_data", req_res_data, dict_fn(make_ids(int'(e[7:5]), int'(e[4:1]))));
                  check("res_keep", req_res_keep, keep_of(int'(e[7:5]), e[0]));
                  check("res_last", req_res_last, e[0]);
               end
            end
         end
         if (hits != 0 || (dict_res_valid && dict_res_ready))
            check("res_pairing", {hits == 1, dict_res_valid && dict_res_ready}, 2'b11);
      end
   end

   // directed tests
   initial begin
      int total;
      n_tests       = 0;
      n_fail        = 0;
      rst           = 1'b1;
      res_en        = 1'b1;
      req_res_ready = 4'hF;
      do_reset(1'b0);

      // single requester, 3-beat packet, then rr_ptr=1 makes requester 1 win over 0
      @(posedge clk); #1;
      push_pend(0, 0, 0); push_pend(0, 1, 0); push_pend(0, 2, 1);
      push_exp(0, 0, 0);  push_exp(0, 1, 0);  push_exp(0, 2, 1);
      wait_drain("t1");
      @(posedge clk); #1;
      push_pend(0, 3, 1); push_pend(1, 0, 1);
      push_exp(1, 0, 1);  push_exp(0, 3, 1);
      wait_drain("t1_rr");

      // all four requesters with 2-beat packets from reset
      do_reset(1'b0);
      @(posedge clk); #1;
      for (int r = 0; r < 4; r++) begin
         push_pend(r, 0, 0); push_pend(r, 1, 1);
      end
      for (int r = 0; r < 4; r++) begin
         push_exp(r, 0, 0); push_exp(r, 1, 1);
      end
      wait_drain("t2");

      // requester 2 locked mid-packet while 0,1,3 are valid
      @(posedge clk); #1;
      push_pend(2, 0, 0);
      push_exp(2, 0, 0);
      wait_ids_idle("t3_first");
      push_pend(0, 0, 1); push_pend(1, 0, 1); push_pend(3, 0, 1);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk); #4;
         check("t3_hold_dict_valid", dict_ids_valid, 0);
         check("t3_hold_grant", grant, 2);
         check("t3_hold_state", state_dbg, 1);
      end
      @(posedge clk); #1;
      push_pend(2, 1, 1);
      push_exp(2, 1, 1); push_exp(3, 0, 1); push_exp(0, 0, 1); push_exp(1, 0, 1);
      wait_drain("t3");

      // dictionary stalled: 9 single-beat packets, only ROUTE_DEPTH accepted
      do_reset(1'b0);
      @(posedge clk); #1;
      res_en = 1'b0;
      for (int b = 0; b < 3; b++) push_pend(0, b, 1);
      for (int r = 1; r < 4; r++) begin
         push_pend(r, 0, 1); push_pend(r, 1, 1);
      end
      for (int b = 0; b < 2; b++)
         for (int r = 0; r < 4; r++) push_exp(r, b, 1);
      push_exp(0, 2, 1);
      repeat (15) @(posedge clk);
      #1;
      total = pend_q[0].size() + pend_q[1].size() + pend_q[2].size() + pend_q[3].size();
      check("t4_pending_after_full", total, 1);
      check("t4_pending_owner", pend_q[0].size(), 1);
      @(negedge clk); #4;
      check("t4_full_dict_valid", dict_ids_valid, 0);
      check("t4_full_req_ready", req_ids_ready, 0);
      check("t4_full_busy", busy, 1);
      @(posedge clk); #1;
      res_en = 1'b1;
      @(negedge clk); #4;
      check("t4_pop_res_ready", dict_res_ready, 1);
      check("t4_pop_no_unblock", dict_ids_valid, 0);
      @(negedge clk); #4;
      check("t4_unblocked", dict_ids_valid, 1);
      wait_drain("t4");

      // results 1,3,1 outstanding, requester 3 not ready for 4 cycles
      do_reset(1'b0);
      @(posedge clk); #1;
      res_en = 1'b0;
      push_pend(1, 0, 1); push_pend(1, 1, 1); push_pend(3, 0, 1);
      push_exp(1, 0, 1);  push_exp(3, 0, 1);  push_exp(1, 1, 1);
      wait_ids_idle("t5_ids");
      req_res_ready = 4'b0111;
      res_en        = 1'b1;
      @(negedge clk); #4;
      check("t5_first_owner", req_res_valid, 4'b0010);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk); #4;
         check("t5_stall_valid", req_res_valid, 4'b1000);
         check("t5_stall_ready", dict_res_ready, 0);
      end
      @(posedge clk); #1;
      req_res_ready = 4'hF;
      wait_drain("t5");

      // reset with 3 beats in flight, then a fresh packet
      @(posedge clk); #1;
      res_en = 1'b0;
      push_pend(0, 0, 0); push_pend(0, 1, 0); push_pend(0, 2, 1);
      push_exp(0, 0, 0);  push_exp(0, 1, 0);  push_exp(0, 2, 1);
      wait_ids_idle("t6_ids");
      check("t6_busy_in_flight", busy, 1);
      req_res_ready = 4'h0;
      res_en        = 1'b1;
      @(negedge clk); #4;
      check("t6_head_valid", req_res_valid, 4'b0001);
      check("t6_head_blocked", dict_res_ready, 0);
      do_reset(1'b1);
      @(posedge clk); #1;
      push_pend(0, 4, 0); push_pend(0, 5, 1);
      push_exp(0, 4, 0);  push_exp(0, 5, 1);
      wait_drain("t6");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
